cga_composite_enc: RTL and testbench
====================================

// Module: cga_composite_enc
// PURPOSE
// - Encodes the 4-bit IRGB pixel stream and CRTC sync/blank timing into a 7-bit NTSC-style composite sample stream.
// - Produces sync tips, colour burst, luma, and an 8-phase square-wave chroma carrier.
// - Transmit-side counterpart of the composite-to-RGB approximation in the VGA port.
// - Sits after the CGA pixel serializer; feeds the composite DAC / TV-out path.
// PARAMETERS
// - BLANK_LVL   24  blank/black pedestal level
// - INT_AMP     24  level added when intensity bit I=1
// - CHROMA_AMP  40  chroma high-half amplitude; also the constant offset added for colour 7
// - BURST_AMP   20  burst high-half amplitude above BLANK_LVL
// - BURST_DLY    8  clocks from hsync fall to burst start (breezeway)
// - BURST_LEN   72  burst length in clocks (9 carrier cycles)
// PORTS
// - clk        in   1  28.636 MHz (8 x 3.579545 MHz); one chroma cycle = 8 clocks
// - reset_n    in   1  asynchronous, active-low reset
// - video      in   4  IRGB pixel {I,R,G,B}, sampled every clk
// - hsync      in   1  horizontal sync, active high
// - vsync      in   1  vertical sync, active high
// - hblank     in   1  horizontal blank
// - vblank     in   1  vertical blank
// - color_en   in   1  1 = chroma and burst enabled; 0 = mono (640-px mode)
// - comp       out  7  composite sample, 0 = sync tip, 127 = max
// - comp_sync  out  1  registered copy of (hsync|vsync), aligned with comp
// BEHAVIOUR
// - Reset: comp=0, comp_sync=0, phase=0, FSM=BLANK, pipeline registers cleared.
// - Phase: 3-bit counter, free-running, +1 every clk, wraps 7->0.
//   - Never resynchronised by sync, so burst phase is stable line to line.
// - Chroma: for RGB code k in 1..6, chroma_hi = ((phase - PHASE_LUT[k]) mod 8) < 4.
//   - k=0: chroma_hi=0. k=7: constant +CHROMA_AMP, no carrier.
// - Latency: 2 clocks.
//   - Stage 1 registers video/hsync/vsync/hblank/vblank/phase.
//   - Stage 2 runs the FSM and registers comp and comp_sync.
// - FSM states: ACTIVE, BLANK, SYNC, BREEZE, BURST.
//   - any -> SYNC when hsync|vsync; SYNC is top priority and pre-empts BREEZE/BURST immediately.
//   - SYNC -> BREEZE on hsync fall with vsync=0. If vsync is still 1, stay in SYNC.
//   - BREEZE: count BURST_DLY clocks -> BURST.
//   - BURST: count BURST_LEN clocks -> BLANK, or -> ACTIVE if hblank|vblank is already 0.
//   - BLANK -> ACTIVE when hblank=0 and vblank=0; ACTIVE -> BLANK when hblank|vblank.
//   - An hblank fall during BREEZE/BURST is ignored until the burst completes; pixels are blanked meanwhile.
// - Output level by state:
//   - SYNC: 0.
//   - BLANK, BREEZE: BLANK_LVL.
//   - BURST: BLANK_LVL + (burst_hi ? BURST_AMP : 0), where burst_hi uses PHASE_LUT[6].
//     - With color_en=0 the burst is replaced by BLANK_LVL (state sequence unchanged).
//   - ACTIVE: BLANK_LVL + I*INT_AMP + chroma term.
//     - chroma term = chroma_hi*CHROMA_AMP for k=1..6, CHROMA_AMP for k=7.
//     - With color_en=0: chroma term = CHROMA_AMP/2 if k!=0, else 0.
// - Arithmetic: 8-bit unsigned sum, saturated to 127 before assignment to comp.
// - Mid-operation reset forces the reset values immediately (async); after release, FSM restarts in BLANK.
// STRUCTURE
// - Package cga_comp_pkg:
//   - state enum {ACTIVE, BLANK, SYNC, BREEZE, BURST}.
//   - PHASE_LUT[1..6] = {1:4, 2:1, 3:7, 4:0, 5:5, 6:2}.
//   - Level-width localparam (7).
// - Sub-module cga_comp_phase:
//   - Holds the phase counter and the chroma_hi / burst_hi generator.
//   - Inputs: clk, reset_n, rgb[2:0]. Outputs: phase[2:0], chroma_hi, burst_hi.
// TESTING
// - Reset, then ACTIVE with video=4'h0 -> comp=24 steady; video=4'hF, color_en=1 -> comp=88 two clocks later.
// - Active, video=4'h1, color_en=1 -> comp repeats 24,24,24,24,64,64,64,64 aligned to phase 0..7 (high at phases 4-7).
// - hsync rise during ACTIVE -> comp=0 and comp_sync=1 exactly 2 clocks later.
//   - After hsync fall: 8 clocks of 24, then 72 clocks alternating 24/44 in 4-clock halves, then 24.
// - hsync asserted mid-BURST -> burst aborted, comp=0 within 2 clocks.
//   - vsync held across hsync fall -> stays 0, no burst.
// - color_en=0: video=4'hA -> 24+24+20=68 constant, burst window flat at 24; video=4'h8 -> 48.
// - Assert reset_n=0 mid-burst -> comp=0 asynchronously; after release with hblank=1 -> 24 and phase restarts at 0.

Source files
------------

// File: rtl/cga_comp_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | cga_comp_pkg : shared types, widths and chroma phase table for the      |
// |                CGA composite encoder.             Rev 1.0               |
// +-------------------------------------------------------------------------+
package cga_comp_pkg;

    localparam int LVL_W = 7;

    typedef enum logic [2:0] {
        ST_ACTIVE = 3'd0,
        ST_BLANK  = 3'd1,
        ST_SYNC   = 3'd2,
        ST_BREEZE = 3'd3,
        ST_BURST  = 3'd4
    } state_t;

    typedef struct packed {
        logic [3:0] video;
        logic       hsync;
        logic       vsync;
        logic       hblank;
        logic       vblank;
        logic       chroma_hi;
        logic       burst_hi;
    } s1_t;

    // Carrier phase offset (in 1/8 cycles) for each RGB hue; 0 and 7 have no carrier.
    function automatic logic [2:0] phase_lut(input logic [2:0] k);
        logic [2:0] p;
        case (k)
            3'd1:    p = 3'd4;
            3'd2:    p = 3'd1;
            3'd3:    p = 3'd7;
            3'd4:    p = 3'd0;
            3'd5:    p = 3'd5;
            3'd6:    p = 3'd2;
            default: p = 3'd0;
        endcase
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cga_composite_enc_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | cga_composite_enc_if : pixel/timing inputs and composite outputs.       |
// |                                                  Rev 1.0                |
// +-------------------------------------------------------------------------+
interface cga_composite_enc_if;
    import cga_comp_pkg::*;

    logic [3:0]       video;
    logic             hsync;
    logic             vsync;
    logic             hblank;
    logic             vblank;
    logic             color_en;
    logic [LVL_W-1:0] comp;
    logic             comp_sync;
    logic [2:0]       phase;

    modport master (
        output video, hsync, vsync, hblank, vblank, color_en,
        input  comp, comp_sync, phase
    );

    modport slave (
        input  video, hsync, vsync, hblank, vblank, color_en,
        output comp, comp_sync, phase
    );
endinterface
`default_nettype wire

// File: rtl/cga_comp_phase.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | cga_comp_phase : free-running 8-step carrier phase and hue square wave. |
// |                                                  Rev 1.0                |
// +-------------------------------------------------------------------------+
module cga_comp_phase
    import cga_comp_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] rgb,
    output logic [2:0] phase,
    output logic       chroma_hi,
    output logic       burst_hi
);
    logic [2:0] phase_d;
    logic [2:0] phase_q;
    logic [2:0] chroma_off;
    logic [2:0] burst_off;

    always_comb begin
        phase_d    = phase_q + 3'd1;
        chroma_off = phase_q - phase_lut(rgb);
        burst_off  = phase_q - phase_lut(3'd6);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= 3'd0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign phase     = phase_q;
    assign chroma_hi = (rgb != 3'd0) && (rgb != 3'd7) && (chroma_off < 3'd4);
    assign burst_hi  = (burst_off < 3'd4);
endmodule
`default_nettype wire

// File: rtl/cga_composite_enc.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | cga_composite_enc : IRGB + CRTC timing to 7-bit composite samples,      |
// |                     two-stage pipeline.              Rev 1.0            |
// +-------------------------------------------------------------------------+
module cga_composite_enc
    import cga_comp_pkg::*;
#(
    parameter int unsigned BLANK_LVL  = 24,
    parameter int unsigned INT_AMP    = 24,
    parameter int unsigned CHROMA_AMP = 40,
    parameter int unsigned BURST_AMP  = 20,
    parameter int unsigned BURST_DLY  = 8,
    parameter int unsigned BURST_LEN  = 72
) (
    input  logic                clk,
    input  logic                reset_n,
    cga_composite_enc_if.slave  bus
);
    localparam logic [7:0] C_BLANK   = 8'(BLANK_LVL);
    localparam logic [7:0] C_INT     = 8'(INT_AMP);
    localparam logic [7:0] C_CHROMA  = 8'(CHROMA_AMP);
    localparam logic [7:0] C_CHR_MON = 8'(CHROMA_AMP / 2);
    localparam logic [7:0] C_BURST   = 8'(BURST_AMP);
    localparam logic [7:0] C_DLY_END = 8'(BURST_DLY - 1);
    localparam logic [7:0] C_LEN_END = 8'(BURST_LEN - 1);
    localparam logic [7:0] C_SAT     = 8'((1 << LVL_W) - 1);

    s1_t              s1_d, s1_q;
    state_t           state_d, state_q;
    logic [7:0]       cnt_d, cnt_q;
    logic [7:0]       level;
    logic [LVL_W-1:0] comp_d, comp_q;
    logic             comp_sync_d, comp_sync_q;
    logic             sync, blanked;
    logic             chroma_hi, burst_hi;
    logic [2:0]       phase;

    cga_comp_phase u_phase (
        .clk       (clk),
        .reset_n   (reset_n),
        .rgb       (bus.video[2:0]),
        .phase     (phase),
        .chroma_hi (chroma_hi),
        .burst_hi  (burst_hi)
    );

    always_comb begin
        s1_d.video     = bus.video;
        s1_d.hsync     = bus.hsync;
        s1_d.vsync     = bus.vsync;
        s1_d.hblank    = bus.hblank;
        s1_d.vblank    = bus.vblank;
        s1_d.chroma_hi = chroma_hi;
        s1_d.burst_hi  = burst_hi;
    end

    // Output level follows the next state so a sync edge reaches comp in two clocks.
    always_comb begin
        state_d     = state_q;
        cnt_d       = 8'd0;
        sync        = s1_q.hsync | s1_q.vsync;
        blanked     = s1_q.hblank | s1_q.vblank;
        comp_sync_d = sync;

        if (sync) begin
            state_d = ST_SYNC;
        end else begin
            case (state_q)
                ST_SYNC: begin
                    state_d = ST_BREEZE;
                end
                ST_BREEZE: begin
                    if (cnt_q == C_DLY_END) begin
                        state_d = ST_BURST;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_BURST: begin
                    if (cnt_q == C_LEN_END) begin
                        state_d = blanked ? ST_BLANK : ST_ACTIVE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_BLANK, ST_ACTIVE: begin
                    state_d = blanked ? ST_BLANK : ST_ACTIVE;
                end
                default: begin
                    state_d = ST_BLANK;
                end
            endcase
        end

        level = C_BLANK;
        case (state_d)
            ST_SYNC: begin
                level = 8'd0;
            end
            ST_BURST: begin
                if (bus.color_en && s1_q.burst_hi) begin
                    level = level + C_BURST;
                end
            end
            ST_ACTIVE: begin
                if (s1_q.video[3]) begin
                    level = level + C_INT;
                end
                if (s1_q.video[2:0] != 3'd0) begin
                    if (!bus.color_en) begin
                        level = level + C_CHR_MON;
                    end else if (s1_q.video[2:0] == 3'd7 || s1_q.chroma_hi) begin
                        level = level + C_CHROMA;
                    end
                end
            end
            default: begin
            end
        endcase
        comp_d = (level > C_SAT) ? C_SAT[LVL_W-1:0] : level[LVL_W-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q        <= '0;
            state_q     <= ST_BLANK;
            cnt_q       <= 8'd0;
            comp_q      <= '0;
            comp_sync_q <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            comp_q      <= comp_d;
            comp_sync_q <= comp_sync_d;
        end
    end

    assign bus.comp      = comp_q;
    assign bus.comp_sync = comp_sync_q;
    assign bus.phase     = phase;
endmodule
`default_nettype wire

// File: tb/tb_cga_composite_enc.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_cga_composite_enc : randomized line stimulus, scoreboard vs model.   |
// |                                                  Rev 1.0                |
// +-------------------------------------------------------------------------+
module tb_cga_composite_enc;

    localparam int BLANK = 24, INTA = 24, CHR = 40, BAMP = 20, BDLY = 8, BLEN = 72;
    localparam int IDLE  = 1000;

    typedef struct {
        logic [6:0] comp;
        logic       sync;
    } exp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    cga_composite_enc_if bus ();

    cga_composite_enc dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   ph     = 0;
    int   run    = IDLE;
    int   lut[8] = '{0, 4, 1, 7, 0, 5, 2, 0};

    // run = non-sync samples since the last sync sample (1 = first after sync).
    function automatic int exp_comp(int r, int p, logic [3:0] v, logic hb, logic vb,
                                    logic ce, logic sy);
        int k;
        int lvl;
        if (sy) return 0;
        if (r <= BDLY) return BLANK;
        if (r <= BDLY + BLEN) return BLANK + ((ce && (((p - 2) & 7) < 4)) ? BAMP : 0);
        if (hb || vb) return BLANK;
        k   = int'(v[2:0]);
        lvl = BLANK + (v[3] ? INTA : 0);
        if (k != 0) begin
            if (!ce) lvl += CHR / 2;
            else if (k == 7) lvl += CHR;
            else if (((p - lut[k]) & 7) < 4) lvl += CHR;
        end
        return (lvl > 127) ? 127 : lvl;
    endfunction

    initial begin : model
        exp_t e;
        logic sy;
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                sb.delete();
                ph  = 0;
                run = IDLE;
            end else begin
                sy = bus.hsync | bus.vsync;
                if (sy) run = 0;
                else if (run < IDLE) run++;
                e.sync = sy;
                e.comp = 7'(exp_comp(run, ph, bus.video, bus.hblank, bus.vblank,
                                     bus.color_en, sy));
                sb.push_back(e);
                ph = (ph + 1) % 8;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (reset_n) begin
                checks++;
                if (bus.phase !== 3'(ph)) begin
                    errors++;
                    $display("FAIL phase: got %0d, want %0d at %0t", bus.phase, ph, $time);
                end
                if (sb.size() >= 2) begin
                    e = sb.pop_front();
                    checks++;
                    if (bus.comp !== e.comp || bus.comp_sync !== e.sync) begin
                        errors++;
                        $display("FAIL comp: got comp=%0d sync=%0b, want comp=%0d sync=%0b at %0t",
                                 bus.comp, bus.comp_sync, e.comp, e.sync, $time);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d at %0t", name, got, want, $time);
        end
    endtask

    task automatic rnd(input int n);
        repeat (n) begin
            bus.video = 4'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic hold(input logic [3:0] v, input int n);
        bus.video = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic run_line(input int kind);
        bus.hblank = 1'b1;
        rnd(3 + $urandom_range(0, 4));
        bus.hsync = 1'b1;
        if (kind == 2) bus.vsync = 1'b1;
        rnd(4 + $urandom_range(0, 8));
        if (kind == 3) bus.color_en = ~bus.color_en;
        rnd(4);
        bus.hsync = 1'b0;
        if (kind == 2) begin
            rnd(10);
            bus.hsync = 1'b1;
            rnd(3);
            bus.vsync = 1'b0;
            rnd(5);
            bus.hsync = 1'b0;
        end
        if (kind == 1) begin
            rnd($urandom_range(10, 70));
            bus.hsync = 1'b1;
            rnd(6);
            bus.hsync = 1'b0;
        end
        rnd($urandom_range(20, 100));
        bus.hblank = 1'b0;
        bus.vblank = ($urandom_range(0, 5) == 0);
        rnd($urandom_range(30, 60));
        bus.vblank = 1'b0;
    endtask

    initial begin : stim
        bus.video    = 4'h0;
        bus.hsync    = 1'b0;
        bus.vsync    = 1'b0;
        bus.hblank   = 1'b1;
        bus.vblank   = 1'b0;
        bus.color_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_comp", int'(bus.comp), 0);
        chk("reset_sync", int'(bus.comp_sync), 0);
        chk("reset_phase", int'(bus.phase), 0);
        reset_n = 1'b1;

        hold(4'h0, 5);
        bus.hblank = 1'b0;
        hold(4'h0, 10);
        hold(4'hF, 6);
        hold(4'h1, 24);
        rnd(40);

        for (int ln = 0; ln < 16; ln++) run_line(ln % 4);

        // Mono mode: switch colour off inside a sync pulse.
        bus.hblank = 1'b1;
        bus.hsync  = 1'b1;
        hold(4'hA, 6);
        bus.color_en = 1'b0;
        hold(4'hA, 6);
        bus.hsync = 1'b0;
        hold(4'hA, 90);
        bus.hblank = 1'b0;
        hold(4'hA, 16);
        hold(4'h8, 16);
        rnd(20);

        // Colour back on, then reset in the middle of a burst.
        bus.hblank = 1'b1;
        bus.hsync  = 1'b1;
        rnd(6);
        bus.color_en = 1'b1;
        rnd(6);
        bus.hsync = 1'b0;
        rnd(30);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_rst_comp", int'(bus.comp), 0);
        chk("async_rst_sync", int'(bus.comp_sync), 0);
        chk("async_rst_phase", int'(bus.phase), 0);
        bus.hblank = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        hold(4'h3, 6);
        bus.hblank = 1'b0;
        hold(4'h1, 16);
        rnd(16);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
